timer_sequencer: RTL and testbench



---
 rtl/timer_sequencer_if.sv | 13 +
 rtl/timer_sequencer.sv | 81 ++++++++
 tb/tb_timer_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: command handshake bundle between a command source and the timer sequencer
interface timer_sequencer_if #(
  parameter int WORD_WIDTH   = 20,
  parameter int REPEAT_WIDTH = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_abort;
  logic [WORD_WIDTH-1:0]   cmd_period;
  logic [REPEAT_WIDTH-1:0] cmd_repeat;
  modport master (output cmd_valid, cmd_period, cmd_repeat, cmd_abort, input cmd_ready);
  modport slave  (input cmd_valid, cmd_period, cmd_repeat, cmd_abort, output cmd_ready);
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer: command-driven interval timer sequencing one binary down-counter; optional TIMER_SEQUENCER_PAUSE_EN adds a pause input
module timer_sequencer #(
  parameter int WORD_WIDTH   = 20,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    clear,
`ifdef TIMER_SEQUENCER_PAUSE_EN
  input  logic                    pause,
`endif
  timer_sequencer_if.slave        bus,
  output logic                    busy,
  output logic                    tick,
  output logic                    done,
  output logic                    aborted,
  output logic [WORD_WIDTH-1:0]   count,
  output logic [REPEAT_WIDTH-1:0] periods_left
);
  localparam logic [WORD_WIDTH-1:0]   ONE_W = WORD_WIDTH'(1);
  localparam logic [REPEAT_WIDTH-1:0] ONE_R = REPEAT_WIDTH'(1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state;
  logic [WORD_WIDTH-1:0] period;
  logic                  run;
`ifdef TIMER_SEQUENCER_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif
  assign bus.cmd_ready = (state == IDLE);
  // Sequencer: accept commands, count down, reload or finish on expiry, honour abort.
  // periods_left == 0 while running marks free-running mode, so no separate mode bit is kept.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      busy         <= 1'b0;
      tick         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      count        <= '0;
      periods_left <= '0;
      period       <= '0;
    end else begin
      tick    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_valid) begin
          period       <= bus.cmd_period;
          periods_left <= bus.cmd_repeat;
          count        <= bus.cmd_period - ONE_W;
          state        <= RUN;
          busy         <= 1'b1;
        end
      end else if (run && count == '0) begin
        tick <= 1'b1;
        if (periods_left == ONE_R) begin
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b1;
          periods_left <= '0;
        end else if (bus.cmd_abort) begin
          state        <= IDLE;
          busy         <= 1'b0;
          aborted      <= 1'b1;
          periods_left <= '0;
        end else begin
          count        <= period - ONE_W;
          periods_left <= (periods_left != '0) ? periods_left - ONE_R : periods_left;
        end
      end else if (bus.cmd_abort) begin
        state        <= IDLE;
        busy         <= 1'b0;
        aborted      <= 1'b1;
        periods_left <= '0;
      end else if (run) begin
        count <= count - ONE_W;
      end
    end
  end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: scoreboard bench; driver queues expected pulse events, monitor pops and compares them
module tb_timer_sequencer;
  localparam int WW = 4;
  localparam int RW = 8;
  typedef struct {
    int cyc;
    bit tick;
    bit done;
    bit aborted;
    bit busy;
    int count;
    int pl;
  } ev_t;
  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          busy, tick, done, aborted;
  logic [WW-1:0] count;
  logic [RW-1:0] periods_left;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            hs = 0;
  ev_t           q[$];
`ifdef TIMER_SEQUENCER_PAUSE_EN
  logic          pause = 1'b0;
`endif
  timer_sequencer_if #(.WORD_WIDTH(WW), .REPEAT_WIDTH(RW)) bus ();
  timer_sequencer #(.WORD_WIDTH(WW), .REPEAT_WIDTH(RW)) dut (
    .clock        (clock),
    .clear        (clear),
`ifdef TIMER_SEQUENCER_PAUSE_EN
    .pause        (pause),
`endif
    .bus          (bus.slave),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .aborted      (aborted),
    .count        (count),
    .periods_left (periods_left)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void push(input int c, input bit t, input bit d, input bit a, input bit b, input int cnt, input int pl);
    ev_t e;
    e.cyc = c; e.tick = t; e.done = d; e.aborted = a; e.busy = b; e.count = cnt; e.pl = pl;
    q.push_back(e);
  endfunction
  // Called at a negedge with the sequencer idle; returns #1 after the handshake edge with hs set.
  task automatic issue(input int p, input int r, input bit exp_ticks);
    int pe;
    pe = (p == 0) ? (1 << WW) : p;
    check("cmd_ready_at_issue", int'(bus.cmd_ready), 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_period = WW'(p);
    bus.cmd_repeat = RW'(r);
    @(posedge clock);
    #1;
    hs = cyc;
    bus.cmd_valid = 1'b0;
    if (exp_ticks)
      for (int k = 1; k <= r; k++)
        push(hs + pe * k, 1'b1, k == r, 1'b0, k != r, (k == r) ? 0 : pe - 1, r - k);
  endtask
  task automatic at_neg(input int c);
    do @(negedge clock); while (cyc < c);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.cmd_ready && n < 200);
    check("wait_idle_timeout", int'(bus.cmd_ready), 1);
  endtask
  // Monitor: every pulse the DUT presents must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!clear && (tick || done || aborted)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc %0d tick %0d done %0d aborted %0d", cyc, tick, done, aborted);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.tick != tick || e.done != done || e.aborted != aborted ||
            e.busy != busy || e.count != int'(count) || e.pl != int'(periods_left)) begin
          n_fail++;
          $display("FAIL pulse_event: got cyc %0d t%0d d%0d a%0d busy %0d count %0d pl %0d, expected cyc %0d t%0d d%0d a%0d busy %0d count %0d pl %0d",
                   cyc, tick, done, aborted, busy, count, periods_left,
                   e.cyc, e.tick, e.done, e.aborted, e.busy, e.count, e.pl);
        end
      end
    end
  end
  initial begin
    int prev;
    bus.cmd_valid  = 1'b0;
    bus.cmd_abort  = 1'b0;
    bus.cmd_period = '0;
    bus.cmd_repeat = '0;
    #12 clear = 1'b0;
    @(negedge clock);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_periods_left", int'(periods_left), 0);
    check("rst_pulses", int'({tick, done, aborted}), 0);
    repeat (20) @(negedge clock);
    // single shot
    issue(5, 1, 1'b1);
    at_neg(hs);
    for (int i = 0; i < 5; i++) begin
      check("single_count", int'(count), 4 - i);
      @(negedge clock);
    end
    check("single_busy_falls", int'(busy), 0);
    check("single_ready", int'(bus.cmd_ready), 1);
    @(negedge clock);
    // repeat, then back-to-back free-running command issued in the done cycle
    issue(3, 4, 1'b1);
    at_neg(hs);
    check("repeat_pl_start", int'(periods_left), 4);
    prev = hs;
    wait_idle();
    check("repeat_done_cycle", cyc, prev + 12);
    issue(2, 0, 1'b0);
    check("back_to_back_edge", hs, prev + 13);
    for (int k = 1; k <= 7; k++) push(hs + 2 * k, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
    push(hs + 15, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    at_neg(hs + 14);
    bus.cmd_abort = 1'b1;
    @(negedge clock);
    bus.cmd_abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    // abort on the same edge as the final expiry: expiry wins
    issue(3, 1, 1'b1);
    at_neg(hs + 2);
    bus.cmd_abort = 1'b1;
    @(negedge clock);
    bus.cmd_abort = 1'b0;
    // abort on the same edge as a non-final expiry: tick and abort, no reload
    issue(2, 3, 1'b0);
    push(hs + 2, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    at_neg(hs + 1);
    bus.cmd_abort = 1'b1;
    @(negedge clock);
    bus.cmd_abort = 1'b0;
    repeat (6) @(negedge clock);
    check("abort_nonfinal_count_held", int'(count), 0);
    // period 0 means 2^WW
    issue(0, 1, 1'b1);
    at_neg(hs);
    check("p0_first_count", int'(count), 15);
    wait_idle();
    // period 1: ticks on consecutive cycles
    issue(1, 3, 1'b1);
    wait_idle();
`ifdef TIMER_SEQUENCER_PAUSE_EN
    issue(5, 2, 1'b0);
    push(hs + 9, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1);
    push(hs + 14, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    at_neg(hs + 1);
    pause = 1'b1;
    repeat (4) @(negedge clock);
    pause = 1'b0;
    check("pause_count_frozen", int'(count), 3);
    wait_idle();
`endif
    // asynchronous clear mid-run
    issue(5, 2, 1'b0);
    at_neg(hs + 2);
    #2 clear = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_count", int'(count), 0);
    check("async_pl", int'(periods_left), 0);
    check("async_ready", int'(bus.cmd_ready), 1);
    #1 clear = 1'b0;
    repeat (20) @(negedge clock);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
